calc1_req_seq: RTL and testbench

Per-port request sequencer that sits directly upstream of the calc1 ALU core.
- Accepts the serial host protocol: command plus operand 1 in one cycle, operand 2 in the next.
- Issues the request to the ALU over a valid/ready handshake and waits for completion, bounded by a timeout.
- Returns a one-cycle response (out_resp/out_data) to the host.

---
 rtl/calc1_req_seq_if.sv | 32 +++
 rtl/calc1_req_seq.sv | 113 +++++++++++
 tb/tb_calc1_req_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc1_req_seq_if.sv
// Host/ALU-facing signal bundle for the calc1 request sequencer.
// No logic: the sequencer registers every output it drives.
// Ready only on the ALU side; the host gets no backpressure.
interface calc1_req_seq_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic              alu_valid;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic              alu_ready;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  // Sequencer's view
  modport slave (
    input  req_cmd_in, req_data_in, alu_ready, alu_done, alu_result, alu_ovf,
    output alu_valid, alu_cmd, alu_op1, alu_op2, out_resp, out_data, busy
  );

  // Host + ALU environment's view
  modport master (
    output req_cmd_in, req_data_in, alu_ready, alu_done, alu_result, alu_ovf,
    input  alu_valid, alu_cmd, alu_op1, alu_op2, out_resp, out_data, busy
  );
endinterface

// File: rtl/calc1_req_seq.sv
// Per-port request sequencer: host cmd/op1 then op2 -> ALU valid/ready -> one-cycle response.
// Latency: cmd at T -> alu_valid T+2, out_resp T+4 best case; invalid cmd (or zero bypass) T+2.
// Backpressure: alu_valid held until alu_ready; host commands while busy are dropped.
// Optional: define CALC1_REQ_SEQ_ZERO_BYPASS_EN to answer valid cmds with op2==0 without the ALU.
module calc1_req_seq #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W          = 7
) (
  input logic            clk,
  input logic            rst_n,
  calc1_req_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_OP2 = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Counter value seen in the last WAIT cycle before the timeout fires
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             cmd_ok;

  // Only add, sub, shl and shr are forwarded to the ALU
  always_comb begin
    cmd_ok = (bus.alu_cmd == 4'd1) || (bus.alu_cmd == 4'd2) ||
             (bus.alu_cmd == 4'd5) || (bus.alu_cmd == 4'd6);
  end

  // Request FSM; all outputs registered, out_resp/out_data default to zero every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      bus.alu_valid <= 1'b0;
      bus.alu_cmd   <= 4'd0;
      bus.alu_op1   <= {DATA_W{1'b0}};
      bus.alu_op2   <= {DATA_W{1'b0}};
      bus.out_resp  <= 2'd0;
      bus.out_data  <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.out_resp <= 2'd0;
      bus.out_data <= {DATA_W{1'b0}};
      case (state)
        IDLE: begin
          if (bus.req_cmd_in != 4'd0) begin
            bus.alu_cmd <= bus.req_cmd_in;
            bus.alu_op1 <= bus.req_data_in;
            bus.busy    <= 1'b1;
            state       <= GET_OP2;
          end
        end
        GET_OP2: begin
          // Second operand is taken regardless of what req_cmd_in carries
          bus.alu_op2 <= bus.req_data_in;
          if (!cmd_ok) begin
            bus.out_resp <= 2'd2;
            state        <= RESP;
          end
`ifdef CALC1_REQ_SEQ_ZERO_BYPASS_EN
          else if (bus.req_data_in == {DATA_W{1'b0}}) begin
            // x+0, x-0, x<<0, x>>0 all equal x
            bus.out_resp <= 2'd1;
            bus.out_data <= bus.alu_op1;
            state        <= RESP;
          end
`endif
          else begin
            bus.alu_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.alu_ready) begin
            bus.alu_valid <= 1'b0;
            tmo_cnt       <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A done strobe in the timeout cycle still counts as completion
          if (bus.alu_done) begin
            bus.out_resp <= bus.alu_ovf ? 2'd2 : 2'd1;
            bus.out_data <= bus.alu_result;
            state        <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.out_resp <= 2'd2;
            state        <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.alu_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_req_seq.sv
// Directed bench for calc1_req_seq with a small behavioural ALU responder.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Responder: done strobe done_lat cycles after handshake, can be withheld.
module tb_calc1_req_seq;
  localparam int DATA_W = 32;
  localparam int TMO    = 64;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // ALU responder state
  int          pend     = 0;
  int          done_lat = 1;
  logic        done_en  = 1'b1;
  logic [31:0] pend_res;
  logic        pend_ovf;

  // Observation helpers
  logic valid_seen = 1'b0;
  int   resp_cnt   = 0;

  logic [1:0]  r;
  logic [31:0] d;
  int          lat;
  int          rc;
  int          n;

  calc1_req_seq_if #(.DATA_W(DATA_W)) bus ();

  calc1_req_seq #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .TMO_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the ALU model answers handshakes seen before the edge
  task automatic tick();
    logic [32:0] s;
    if (bus.alu_valid && bus.alu_ready) begin
      pend     = done_lat;
      pend_ovf = 1'b0;
      case (bus.alu_cmd)
        4'd1: begin
          s        = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
          pend_res = s[31:0];
          pend_ovf = s[32];
        end
        4'd2: begin
          pend_res = bus.alu_op1 - bus.alu_op2;
          pend_ovf = bus.alu_op1 < bus.alu_op2;
        end
        4'd5:    pend_res = bus.alu_op1 << bus.alu_op2[4:0];
        4'd6:    pend_res = bus.alu_op1 >> bus.alu_op2[4:0];
        default: pend_res = 32'd0;
      endcase
    end
    @(posedge clk);
    #1;
    bus.alu_done   = 1'b0;
    bus.alu_result = 32'd0;
    bus.alu_ovf    = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && done_en) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = pend_res;
        bus.alu_ovf    = pend_ovf;
      end
    end
    if (bus.alu_valid) valid_seen = 1'b1;
    if (bus.out_resp != 2'd0) resp_cnt++;
  endtask

  // Full host transaction; lat counts cycles from the cmd cycle to the response
  task automatic run_req(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         output logic [1:0] ro, output logic [31:0] dout, output int lo);
    bus.req_cmd_in  = cmd;
    bus.req_data_in = a;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = b;
    tick();
    bus.req_data_in = 32'd0;
    lo = 2;
    while (bus.out_resp == 2'd0 && lo < 200) begin
      tick();
      lo++;
    end
    ro   = bus.out_resp;
    dout = bus.out_data;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd0;
    bus.alu_ready   = 1'b1;
    bus.alu_done    = 1'b0;
    bus.alu_result  = 32'd0;
    bus.alu_ovf     = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.alu_valid), 32'd0);
    chk("rst_cmd",   32'(bus.alu_cmd),   32'd0);
    chk("rst_op1",   bus.alu_op1,        32'd0);
    chk("rst_op2",   bus.alu_op2,        32'd0);
    chk("rst_resp",  32'(bus.out_resp),  32'd0);
    chk("rst_data",  bus.out_data,       32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in the middle of WAIT aborts the request silently
    done_en         = 1'b0;
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd11;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd22;
    tick();
    bus.req_data_in = 32'd0;
    tick();
    tick();
    chk("midwait_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.alu_valid), 32'd0);
    chk("arst_cmd",   32'(bus.alu_cmd),   32'd0);
    chk("arst_op1",   bus.alu_op1,        32'd0);
    chk("arst_op2",   bus.alu_op2,        32'd0);
    chk("arst_resp",  32'(bus.out_resp),  32'd0);
    chk("arst_data",  bus.out_data,       32'd0);
    chk("arst_busy",  32'(bus.busy),      32'd0);
    pend = 0;
    tick();
    rst_n   = 1'b1;
    done_en = 1'b1;
    rc      = resp_cnt;
    for (int k = 0; k < 5; k++) tick();
    chk("arst_no_resp", 32'(resp_cnt - rc), 32'd0);
    run_req(4'd2, 32'd9, 32'd4, r, d, lat);
    chk("post_rst_resp", 32'(r), 32'd1);
    chk("post_rst_data", d, 32'd5);
    chk("post_rst_lat",  32'(lat), 32'd4);
    tick();

    // Add 1+2 with cycle-by-cycle timing
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'h0000_0001;
    tick();
    chk("add_t1_busy",  32'(bus.busy),      32'd1);
    chk("add_t1_valid", 32'(bus.alu_valid), 32'd0);
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'h0000_0002;
    tick();
    bus.req_data_in = 32'd0;
    chk("add_t2_valid", 32'(bus.alu_valid), 32'd1);
    chk("add_t2_cmd",   32'(bus.alu_cmd),   32'd1);
    chk("add_t2_op1",   bus.alu_op1,        32'd1);
    chk("add_t2_op2",   bus.alu_op2,        32'd2);
    tick();
    chk("add_t3_valid", 32'(bus.alu_valid), 32'd0);
    chk("add_t3_resp",  32'(bus.out_resp),  32'd0);
    tick();
    chk("add_t4_resp",  32'(bus.out_resp),  32'd1);
    chk("add_t4_data",  bus.out_data,       32'd3);
    chk("add_t4_busy",  32'(bus.busy),      32'd1);
    tick();
    chk("add_t5_resp",  32'(bus.out_resp),  32'd0);
    chk("add_t5_data",  bus.out_data,       32'd0);
    chk("add_t5_busy",  32'(bus.busy),      32'd0);

    // Walking bit plus zero
    for (int i = 0; i < 31; i++) begin
      valid_seen = 1'b0;
      run_req(4'd1, 32'd1 << i, 32'd0, r, d, lat);
      chk($sformatf("walk%0d_resp", i), 32'(r), 32'd1);
      chk($sformatf("walk%0d_data", i), d, 32'd1 << i);
`ifdef CALC1_REQ_SEQ_ZERO_BYPASS_EN
      chk($sformatf("walk%0d_novalid", i), 32'(valid_seen), 32'd0);
`else
      chk($sformatf("walk%0d_valid", i), 32'(valid_seen), 32'd1);
`endif
      tick();
    end

    // Overflowing add
    run_req(4'd1, 32'hFFFF_FFFF, 32'd1, r, d, lat);
    chk("ovf_resp", 32'(r), 32'd2);
    chk("ovf_data", d, 32'd0);
    tick();

    // Invalid command never reaches the ALU
    valid_seen = 1'b0;
    run_req(4'd3, 32'd5, 32'd7, r, d, lat);
    chk("inv_resp",    32'(r), 32'd2);
    chk("inv_data",    d, 32'd0);
    chk("inv_lat",     32'(lat), 32'd2);
    chk("inv_novalid", 32'(valid_seen), 32'd0);
    tick();
    chk("inv_pulse", 32'(bus.out_resp), 32'd0);

    // Backpressure: ready low for 5 ISSUE cycles
    bus.alu_ready   = 1'b0;
    bus.req_cmd_in  = 4'd2;
    bus.req_data_in = 32'd10;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd3;
    tick();
    bus.req_data_in = 32'd0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(bus.alu_valid), 32'd1);
      chk($sformatf("bp%0d_cmd", k),   32'(bus.alu_cmd),   32'd2);
      chk($sformatf("bp%0d_op1", k),   bus.alu_op1,        32'd10);
      chk($sformatf("bp%0d_op2", k),   bus.alu_op2,        32'd3);
      tick();
    end
    bus.alu_ready = 1'b1;
    chk("bp_hs_valid", 32'(bus.alu_valid), 32'd1);
    tick();
    chk("bp_drop_valid", 32'(bus.alu_valid), 32'd0);
    tick();
    chk("bp_resp", 32'(bus.out_resp), 32'd1);
    chk("bp_data", bus.out_data, 32'd7);
    tick();

    // Timeout: done withheld, response exactly TMO cycles after entering WAIT
    done_en         = 1'b0;
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd4;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd5;
    tick();
    bus.req_data_in = 32'd0;
    tick();
    n = 0;
    while (bus.out_resp == 2'd0 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_resp",   32'(bus.out_resp), 32'd2);
    chk("tmo_data",   bus.out_data, 32'd0);
    tick();
    chk("tmo_pulse",  32'(bus.out_resp), 32'd0);
    done_en = 1'b1;

    // Command during WAIT is dropped
    rc       = resp_cnt;
    done_lat = 6;
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd20;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd22;
    tick();
    bus.req_data_in = 32'd0;
    tick();
    tick();
    chk("drop_busy", 32'(bus.busy), 32'd1);
    bus.req_cmd_in  = 4'd2;
    bus.req_data_in = 32'd100;
    tick();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd50;
    tick();
    bus.req_data_in = 32'd0;
    lat = 6;
    while (bus.out_resp == 2'd0 && lat < 100) begin
      tick();
      lat++;
    end
    chk("drop_lat",  32'(lat), 32'd9);
    chk("drop_resp", 32'(bus.out_resp), 32'd1);
    chk("drop_data", bus.out_data, 32'd42);
    chk("drop_cmd",  32'(bus.alu_cmd), 32'd1);
    for (int k = 0; k < 6; k++) tick();
    chk("drop_one_resp", 32'(resp_cnt - rc), 32'd1);
    chk("drop_idle",     32'(bus.busy), 32'd0);
    done_lat = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
